// File: rtl/imem_loader.sv
// imem_loader: assembles a little-endian byte stream into 32-bit words for the instruction-memory write port.
// Optional build macro: IMEM_LOADER_CHECKSUM_EN adds a trailing 8-bit XOR checksum byte per load.
module imem_loader #(
  parameter int ADDR_W      = 10,
  parameter int LANE_B_BASE = 512,
  parameter int MAX_WORDS   = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              lane_sel,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CSUM,
`endif
    DONE,
    ERR
  } state_t;

  // State entered once the payload has been consumed (or was empty).
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t POST_DATA = CSUM;
`else
  localparam state_t POST_DATA = DONE;
`endif

  state_t            state, stateNext;
  logic              laneB;
  logic [1:0]        byteCnt;
  logic [7:0]        lenLo;
  logic [23:0]       partial;
  logic [15:0]       wordIdx;
  logic [15:0]       nWords;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  logic              accept;
  logic              startOk;
  logic              lenLast;
  logic              wordLast;
  logic              lastWord;
  logic [15:0]       lenWord;
  logic [ADDR_W-1:0] baseAddr;

  // Ready in every in-load state (including ERR, which drains); never mid-load back-pressure.
  assign in_ready = (state != IDLE) && (state != DONE);
  assign cpu_hold = in_ready;
  assign done     = (state == DONE);
  assign error    = (state == ERR);

  assign accept   = in_valid && in_ready;
  assign startOk  = start && ((state == IDLE) || (state == DONE) || (state == ERR));
  assign lenWord  = {in_data, lenLo};
  assign lenLast  = (state == LEN) && accept && byteCnt[0];
  assign wordLast = (state == DATA) && accept && (byteCnt == 2'd3);
  assign lastWord = ((wordIdx + 16'd1) == nWords);
  assign baseAddr = laneB ? ADDR_W'(LANE_B_BASE) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    // NOTE: default assigned first so every path drives stateNext and no latch is inferred.
    stateNext = state;
    if (startOk) begin
      stateNext = LEN;
    end else begin
      case (state)
        LEN: begin
          if (lenLast) begin
            if (lenWord > 16'(MAX_WORDS)) stateNext = ERR;
            else if (lenWord == 16'd0)    stateNext = POST_DATA;
            else                          stateNext = DATA;
          end
        end
        DATA: begin
          if (wordLast && lastWord) stateNext = POST_DATA;
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CSUM: begin
          if (accept) stateNext = (in_data == csum) ? DONE : ERR;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      laneB     <= 1'b0;
      byteCnt   <= '0;
      lenLo     <= '0;
      partial   <= '0;
      wordIdx   <= '0;
      nWords    <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      // NOTE: non-blocking only in clocked blocks, so every register samples pre-edge values.
      mem_we <= 1'b0;
      if (startOk) begin
        laneB   <= lane_sel;
        byteCnt <= '0;
        wordIdx <= '0;
        nWords  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum    <= '0;
`endif
      end else if (accept && (state == LEN)) begin
        if (!byteCnt[0]) begin
          lenLo   <= in_data;
          byteCnt <= 2'd1;
        end else begin
          nWords  <= lenWord;
          byteCnt <= 2'd0;
        end
      end else if (accept && (state == DATA)) begin
        byteCnt <= byteCnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum    <= csum ^ in_data;
`endif
        // The fourth byte completes the word; mem_addr/mem_wdata otherwise hold.
        if (byteCnt == 2'd3) begin
          mem_we    <= 1'b1;
          mem_addr  <= baseAddr + wordIdx[ADDR_W-1:0];
          mem_wdata <= {in_data, partial};
          wordIdx   <= wordIdx + 16'd1;
        end else begin
          partial[{byteCnt, 3'b000} +: 8] <= in_data;
        end
      end
    end
  end

endmodule
